// File: rtl/amiga_bus_initiator.sv
// 68040-style local-bus master for the CLK40 bus: arbitrates, issues TSn and runs single or
// 4-beat line transfers, ending each beat on TACKn, TEAn or a wait-state timeout.
module amiga_bus_initiator #(
  parameter int         TIMEOUT_CYC = 256,
  parameter logic [1:0] TT_NORMAL   = 2'b00,
  parameter logic [2:0] TM_DATA     = 3'b001
) (
  input  logic         CLK40,
  input  logic         RESET,
  input  logic         REQ,
  input  logic [31:0]  REQ_A,
  input  logic         REQ_RNW,
  input  logic [1:0]   REQ_SIZ,
  input  logic [127:0] REQ_WD,
  output logic         BUSY,
  output logic         DONE,
  output logic [1:0]   ERR,
  output logic [31:0]  RD,
  output logic         RD_VALID,
  output logic         BRn,
  input  logic         BGn,
  input  logic         BBn_IN,
  output logic         BBn_OUT,
  output logic         BB_OE,
  output logic         TSn,
  output logic [31:0]  A_OUT,
  output logic         ADDR_OE,
  output logic [1:0]   TT_OUT,
  output logic [2:0]   TM_OUT,
  output logic [1:0]   SIZ_OUT,
  output logic         RNW_OUT,
  output logic [31:0]  D_OUT,
  output logic         D_OE,
  input  logic [31:0]  D_IN,
  input  logic         TACKn,
  input  logic         TEAn,
  output logic [2:0]   dbg_state
);

  // Engine handshake: REQ is a request-valid that is only taken while BUSY=0 (IDLE); the
  // REQ_* fields are latched on that edge. BUSY stays high until the cycle after DONE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_END   = 3'd4
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);

  state_t       state, state_nxt;
  logic         rnw_q;
  logic [1:0]   siz_q;
  logic [31:0]  a_q;
  logic [127:0] wd_q;
  logic [1:0]   beat_q;
  logic [9:0]   tcnt_q;
  logic [31:0]  a_out_q;
  logic [31:0]  d_out_q;
  logic [31:0]  rd_q;
  logic         rd_valid_q;
  logic [1:0]   err_q;

  logic is_line, tea, tack, last_beat, timeout, granted;

  assign is_line   = (siz_q == 2'b11);
  assign tea       = !TEAn;
  assign tack      = !TACKn && TEAn;
  assign last_beat = !is_line || (beat_q == 2'd3);
  assign timeout   = TEAn && TACKn && (tcnt_q == TMO_LAST);
  assign granted   = !BGn && BBn_IN;

  // 68040 lane placement: bytes and words are replicated across the 32-bit data bus.
  function automatic logic [31:0] lane_data(input logic [1:0] siz, input logic [127:0] wd,
                                            input logic [1:0] beat);
    case (siz)
      2'b01:   lane_data = {4{wd[7:0]}};
      2'b10:   lane_data = {2{wd[15:0]}};
      2'b11:   lane_data = wd[32*int'(beat) +: 32];
      default: lane_data = wd[31:0];
    endcase
  endfunction

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (REQ) state_nxt = S_ARB;
      S_ARB:   if (granted) state_nxt = S_START;
      S_START: state_nxt = S_DATA;
      S_DATA: begin
        if (tea || (tack && last_beat) || timeout) state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BRn     = 1'b1;
    BB_OE   = 1'b0;
    BBn_OUT = 1'b1;
    TSn     = 1'b1;
    ADDR_OE = 1'b0;
    D_OE    = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state)
      S_ARB: begin
        BRn  = 1'b0;
        BUSY = 1'b1;
      end
      S_START, S_DATA: begin
        BB_OE   = 1'b1;
        BBn_OUT = 1'b0;
        TSn     = (state != S_START);
        ADDR_OE = 1'b1;
        D_OE    = !rnw_q;
        BUSY    = 1'b1;
      end
      // BBn is actively driven high for one cycle before the driver is released.
      S_END: begin
        BB_OE = 1'b1;
        BUSY  = 1'b1;
        DONE  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      rnw_q      <= 1'b0;
      siz_q      <= 2'b00;
      a_q        <= '0;
      wd_q       <= '0;
      beat_q     <= 2'd0;
      tcnt_q     <= '0;
      a_out_q    <= '0;
      d_out_q    <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            rnw_q <= REQ_RNW;
            siz_q <= REQ_SIZ;
            a_q   <= REQ_A;
            wd_q  <= REQ_WD;
            err_q <= 2'b00;
          end
        end
        S_ARB: begin
          if (granted) begin
            a_out_q <= is_line ? {a_q[31:4], 4'b0000} : a_q;
            d_out_q <= lane_data(siz_q, wd_q, 2'd0);
            beat_q  <= 2'd0;
            tcnt_q  <= '0;
          end
        end
        S_DATA: begin
          if (tea) begin
            err_q <= 2'b01;
          end else if (tack) begin
            if (rnw_q) begin
              rd_q       <= D_IN;
              rd_valid_q <= 1'b1;
            end
            if (last_beat) begin
              err_q <= 2'b00;
            end else begin
              beat_q       <= beat_q + 2'd1;
              a_out_q[3:2] <= a_out_q[3:2] + 2'd1;
              d_out_q      <= lane_data(siz_q, wd_q, beat_q + 2'd1);
              tcnt_q       <= '0;
            end
          end else if (timeout) begin
            err_q <= 2'b10;
          end else begin
            tcnt_q <= tcnt_q + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ERR       = err_q;
  assign RD        = rd_q;
  assign RD_VALID  = rd_valid_q;
  assign A_OUT     = a_out_q;
  assign D_OUT     = d_out_q;
  assign TT_OUT    = TT_NORMAL;
  assign TM_OUT    = TM_DATA;
  assign SIZ_OUT   = siz_q;
  assign RNW_OUT   = rnw_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_amiga_bus_initiator.sv
// Bench for amiga_bus_initiator: directed vector table, reset/arbitration corner sequences and
// randomized transfers, all checked against a transfer-level model of the bus protocol.
module tb_amiga_bus_initiator;
  localparam int TMO = 16;

  logic         CLK40 = 1'b0;
  logic         RESET;
  logic         REQ;
  logic [31:0]  REQ_A;
  logic         REQ_RNW;
  logic [1:0]   REQ_SIZ;
  logic [127:0] REQ_WD;
  logic         BUSY, DONE, RD_VALID, BRn, BBn_OUT, BB_OE, TSn, ADDR_OE, RNW_OUT, D_OE;
  logic [1:0]   ERR, TT_OUT, SIZ_OUT;
  logic [2:0]   TM_OUT, dbg_state;
  logic [31:0]  RD, A_OUT, D_OUT, D_IN;
  logic         BGn, BBn_IN, TACKn, TEAn;

  always #5 CLK40 = ~CLK40;

  amiga_bus_initiator #(.TIMEOUT_CYC(TMO)) dut (
    .CLK40(CLK40), .RESET(RESET), .REQ(REQ), .REQ_A(REQ_A), .REQ_RNW(REQ_RNW),
    .REQ_SIZ(REQ_SIZ), .REQ_WD(REQ_WD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RD(RD),
    .RD_VALID(RD_VALID), .BRn(BRn), .BGn(BGn), .BBn_IN(BBn_IN), .BBn_OUT(BBn_OUT),
    .BB_OE(BB_OE), .TSn(TSn), .A_OUT(A_OUT), .ADDR_OE(ADDR_OE), .TT_OUT(TT_OUT),
    .TM_OUT(TM_OUT), .SIZ_OUT(SIZ_OUT), .RNW_OUT(RNW_OUT), .D_OUT(D_OUT), .D_OE(D_OE),
    .D_IN(D_IN), .TACKn(TACKn), .TEAn(TEAn), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         rnw;
    logic [1:0]   siz;
    logic [127:0] wd;
    int           grant_dly;
    int           bb_busy;
    int           ws;
    int           err_beat;
    bit           no_ack;
    bit           seq_din;
    logic [1:0]   exp_err;
    logic [31:0]  exp_a0;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic rnw, input logic [1:0] siz,
                              input logic [127:0] wd, input int g, input int bb, input int ws,
                              input int eb, input bit na, input bit sd, input logic [1:0] ee,
                              input logic [31:0] a0);
    vec_t v;
    v.addr = addr; v.rnw = rnw; v.siz = siz; v.wd = wd; v.grant_dly = g; v.bb_busy = bb;
    v.ws = ws; v.err_beat = eb; v.no_ack = na; v.seq_din = sd; v.exp_err = ee; v.exp_a0 = a0;
    return v;
  endfunction

  // Transfer-level model: beat count, beat address and data-bus image of each write beat.
  function automatic int n_beats(input logic [1:0] siz);
    return (siz == 2'b11) ? 4 : 1;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] addr, input logic [1:0] siz,
                                           input int b);
    if (siz == 2'b11) return (addr & 32'hFFFF_FFF0) + 32'(4 * b);
    return addr;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] siz, input logic [127:0] wd,
                                            input int b);
    logic [127:0] t;
    t = wd >> (32 * b);
    case (siz)
      2'b01:   return 32'(wd[7:0]) * 32'h0101_0101;
      2'b10:   return 32'(wd[15:0]) * 32'h0001_0001;
      2'b11:   return t[31:0];
      default: return wd[31:0];
    endcase
  endfunction

  task automatic idle_inputs();
    REQ = 1'b0; BGn = 1'b1; BBn_IN = 1'b1; TACKn = 1'b1; TEAn = 1'b1; D_IN = '0;
  endtask

  task automatic run_txn(input vec_t v, input bit hold_req);
    int nb, kstar, steps, n, done_beats, exp_steps;
    bit fin;
    logic [31:0] din;
    nb    = n_beats(v.siz);
    kstar = (v.grant_dly > v.bb_busy) ? v.grant_dly : v.bb_busy;
    REQ = 1'b1; REQ_A = v.addr; REQ_RNW = v.rnw; REQ_SIZ = v.siz; REQ_WD = v.wd;
    step();
    steps = 1;
    if (hold_req) begin
      REQ_A = ~v.addr; REQ_WD = ~v.wd; REQ_RNW = ~v.rnw; REQ_SIZ = ~v.siz;
    end else begin
      REQ = 1'b0;
    end
    check("arb_brn", BRn, 0);
    check("arb_busy", BUSY, 1);
    check("arb_tsn", TSn, 1);
    for (int k = 0; k <= kstar; k++) begin
      BGn    = (k < v.grant_dly);
      BBn_IN = !(k < v.bb_busy);
      step();
      steps++;
      if (k < kstar) check("arb_wait_tsn", TSn, 1);
    end
    BGn = 1'b1; BBn_IN = 1'b1;
    check("start_tsn", TSn, 0);
    check("start_brn", BRn, 1);
    check("start_bb_oe", BB_OE, 1);
    check("start_bbn", BBn_OUT, 0);
    check("start_addr_oe", ADDR_OE, 1);
    check("start_d_oe", D_OE, !v.rnw);
    check("start_addr", A_OUT, v.exp_a0);
    check("start_siz", SIZ_OUT, v.siz);
    check("start_rnw", RNW_OUT, v.rnw);
    check("start_tt", TT_OUT, 2'b00);
    check("start_tm", TM_OUT, 3'b001);
    if (!v.rnw) check("start_wdata", D_OUT, exp_wdata(v.siz, v.wd, 0));
    step();
    steps++;
    check("data_tsn", TSn, 1);
    fin = 1'b0;
    done_beats = 0;
    if (v.no_ack) begin
      n = 0;
      while (!DONE && n < TMO + 20) begin
        step();
        steps++;
        n++;
      end
      check("timeout_cycles", n, TMO);
    end else begin
      for (int b = 0; b < nb && !fin; b++) begin
        for (int w = 0; w < v.ws; w++) begin
          step();
          steps++;
          check("ws_done", DONE, 0);
          check("ws_tsn", TSn, 1);
        end
        check("beat_addr", A_OUT, exp_addr(v.addr, v.siz, b));
        check("beat_addr_oe", ADDR_OE, 1);
        if (!v.rnw) check("beat_wdata", D_OUT, exp_wdata(v.siz, v.wd, b));
        din  = v.seq_din ? 32'(b + 1) : $urandom;
        D_IN = din;
        done_beats++;
        if (b == v.err_beat) begin
          TEAn = 1'b0; TACKn = 1'b0; fin = 1'b1;
        end else begin
          TACKn = 1'b0;
          if (v.rnw) exp_q.push_back(din);
          if (b == nb - 1) fin = 1'b1;
        end
        step();
        steps++;
        TACKn = 1'b1; TEAn = 1'b1;
        check("beat_tsn", TSn, 1);
        if (v.rnw && b != v.err_beat) begin
          check("rd_valid", RD_VALID, 1);
          if (exp_q.size() > 0) check("rd_data", RD, exp_q.pop_front());
        end else begin
          check("rd_valid_none", RD_VALID, 0);
        end
        if (!fin) check("mid_done", DONE, 0);
      end
    end
    exp_steps = 3 + kstar + (v.no_ack ? TMO : done_beats * (v.ws + 1));
    check("latency", steps, exp_steps);
    check("end_done", DONE, 1);
    check("end_err", ERR, v.exp_err);
    check("end_addr_oe", ADDR_OE, 0);
    check("end_d_oe", D_OE, 0);
    check("end_bbn", BBn_OUT, 1);
    check("end_bb_oe", BB_OE, 1);
    step();
    check("idle_done", DONE, 0);
    check("idle_busy", BUSY, 0);
    check("idle_bb_oe", BB_OE, 0);
    check("idle_brn", BRn, 1);
    check("sb_empty", exp_q.size(), 0);
    if (hold_req) begin
      REQ = 1'b0;
      step();
      check("req_ignored_brn", BRn, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   nb;
    idle_inputs();
    REQ_A = '0; REQ_RNW = 1'b0; REQ_SIZ = 2'b00; REQ_WD = '0;
    RESET = 1'b1;
    repeat (3) step();
    check("rst_brn", BRn, 1);
    check("rst_bbn", BBn_OUT, 1);
    check("rst_bb_oe", BB_OE, 0);
    check("rst_tsn", TSn, 1);
    check("rst_addr_oe", ADDR_OE, 0);
    check("rst_d_oe", D_OE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_rd", RD, 0);
    check("rst_a_out", A_OUT, 0);
    check("rst_d_out", D_OUT, 0);
    RESET = 1'b0;
    step();

    tbl[0] = mk(32'h00DF_F180, 1'b0, 2'b00, 128'h1234_5678, 2, 0, 0, -1, 0, 0, 2'b00, 32'h00DF_F180);
    tbl[1] = mk(32'h0800_0008, 1'b1, 2'b11, '0, 0, 0, 0, -1, 0, 1, 2'b00, 32'h0800_0000);
    tbl[2] = mk(32'h00BF_E001, 1'b1, 2'b01, '0, 0, 0, 0, -1, 1, 0, 2'b10, 32'h00BF_E001);
    tbl[3] = mk(32'h0020_0010, 1'b0, 2'b11, 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000,
                1, 0, 0, 2, 0, 0, 2'b01, 32'h0020_0010);
    tbl[4] = mk(32'h00C0_1234, 1'b1, 2'b00, '0, 0, 5, 0, -1, 0, 0, 2'b00, 32'h00C0_1234);
    tbl[5] = mk(32'h00DF_F09B, 1'b0, 2'b01, 128'h0000_00A5, 0, 0, 2, -1, 0, 0, 2'b00, 32'h00DF_F09B);
    tbl[6] = mk(32'h00DF_F09A, 1'b0, 2'b10, 128'h0000_BEEF, 1, 1, 1, -1, 0, 0, 2'b00, 32'h00DF_F09A);
    tbl[7] = mk(32'h1000_003C, 1'b0, 2'b11, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
                0, 2, 1, -1, 0, 0, 2'b00, 32'h1000_0030);
    tbl[8] = mk(32'h0F00_0024, 1'b1, 2'b11, '0, 3, 1, 0, 0, 0, 0, 2'b01, 32'h0F00_0020);
    for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0);

    // Reset asserted mid-DATA must drop every driver immediately.
    REQ = 1'b1; REQ_A = 32'h0000_4000; REQ_RNW = 1'b0; REQ_SIZ = 2'b11; REQ_WD = '1;
    step();
    REQ = 1'b0; BGn = 1'b0;
    step();
    BGn = 1'b1;
    step();
    check("pre_rst_addr_oe", ADDR_OE, 1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_brn", BRn, 1);
    check("mid_rst_tsn", TSn, 1);
    check("mid_rst_addr_oe", ADDR_OE, 0);
    check("mid_rst_d_oe", D_OE, 0);
    check("mid_rst_bb_oe", BB_OE, 0);
    check("mid_rst_bbn", BBn_OUT, 1);
    check("mid_rst_busy", BUSY, 0);
    step();
    RESET = 1'b0;
    step();
    check("post_rst_brn", BRn, 1);
    check("post_rst_busy", BUSY, 0);

    for (int i = 0; i < 40; i++) begin
      rv.addr      = $urandom;
      rv.rnw       = 1'($urandom_range(0, 1));
      rv.siz       = 2'($urandom_range(0, 3));
      rv.wd        = {$urandom, $urandom, $urandom, $urandom};
      rv.grant_dly = $urandom_range(0, 3);
      rv.bb_busy   = $urandom_range(0, 3);
      rv.ws        = $urandom_range(0, 3);
      nb           = n_beats(rv.siz);
      rv.err_beat  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      rv.no_ack    = ($urandom_range(0, 9) == 0);
      rv.seq_din   = 1'b0;
      rv.exp_err   = rv.no_ack ? 2'b10 : (rv.err_beat >= 0) ? 2'b01 : 2'b00;
      rv.exp_a0    = exp_addr(rv.addr, rv.siz, 0);
      run_txn(rv, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
